// File: rtl/mem_arb_pkg.sv
// Shared constants and helpers for the memory refill arbiter.
// Requester IDs, line geometry and ID FIFO sizing.
package mem_arb_pkg;
  localparam int ADDR_WIDTH      = 64;
  localparam int LINE_SIZE       = 512;
  localparam int OFFSET_WIDTH    = 6;
  localparam int MAX_OUTSTANDING = 4;
  localparam int CNT_WIDTH       = 3;

  localparam logic REQ_ICACHE = 1'b0;
  localparam logic REQ_DCACHE = 1'b1;

  function automatic logic [ADDR_WIDTH-1:0] line_align(
    input logic [ADDR_WIDTH-1:0] a
  );
    return {a[ADDR_WIDTH-1:OFFSET_WIDTH], {OFFSET_WIDTH{1'b0}}};
  endfunction
endpackage

// File: rtl/arb_id_fifo.sv
// In-order FIFO of 1-bit requester IDs for issued memory reads.
// Pointers wrap naturally because DEPTH is a power of two.
module arb_id_fifo #(
  parameter int DEPTH = 4,
  parameter int CW    = 3
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          push,
  input  logic          din,
  input  logic          pop,
  output logic          dout,
  output logic          full,
  output logic          empty,
  output logic [CW-1:0] count
);
  localparam int PW = $clog2(DEPTH);

  logic [DEPTH-1:0] mem;
  logic [PW-1:0]    wr_ptr;
  logic [PW-1:0]    rd_ptr;
  logic             push_ok;
  logic             pop_ok;

  assign full    = (count == CW'(DEPTH));
  assign empty   = (count == '0);
  assign dout    = mem[rd_ptr];
  assign push_ok = push & ~full;
  assign pop_ok  = pop & ~empty;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mem    <= '0;
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push_ok) begin
        mem[wr_ptr] <= din;
        wr_ptr      <= wr_ptr + 1'b1;
      end
      if (pop_ok)
        rd_ptr <= rd_ptr + 1'b1;
      count <= count
             + {{(CW-1){1'b0}}, push_ok}
             - {{(CW-1){1'b0}}, pop_ok};
    end
  end
endmodule

// File: rtl/mem_refill_arbiter.sv
// Round-robin sharing of the line read port between I$ and D$ misses,
// with in-order steering of refill lines back to the owning cache.
module mem_refill_arbiter
  import mem_arb_pkg::*;
(
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  icache_miss_valid_i,
  output logic                  icache_miss_ready_o,
  input  logic [ADDR_WIDTH-1:0] icache_miss_addr_i,
  output logic                  refill_icache_valid_o,
  input  logic                  refill_icache_ready_i,
  output logic [LINE_SIZE-1:0]  refill_icache_data_o,
  input  logic                  dcache_miss_valid_i,
  output logic                  dcache_miss_ready_o,
  input  logic [ADDR_WIDTH-1:0] dcache_miss_addr_i,
  output logic                  refill_dcache_valid_o,
  input  logic                  refill_dcache_ready_i,
  output logic [LINE_SIZE-1:0]  refill_dcache_data_o,
  output logic                  mem_req_valid_o,
  input  logic                  mem_req_ready_i,
  output logic [ADDR_WIDTH-1:0] mem_req_addr_o,
  input  logic                  mem_resp_valid_i,
  output logic                  mem_resp_ready_o,
  input  logic [LINE_SIZE-1:0]  mem_resp_data_i,
  output logic [CNT_WIDTH-1:0]  outstanding_o,
  output logic                  resp_err_o
);
  logic rr_last;
  logic grant_d;
  logic full;
  logic empty;
  logic push;
  logic pop;
  logic head;
  logic head_i;
  logic head_d;

  // Both valid: the one that did not win last time goes.
  assign grant_d = dcache_miss_valid_i
                 & (~icache_miss_valid_i | (rr_last == REQ_ICACHE));

  assign mem_req_valid_o = (icache_miss_valid_i | dcache_miss_valid_i)
                         & ~full;
  assign mem_req_addr_o  = line_align(grant_d ? dcache_miss_addr_i
                                              : icache_miss_addr_i);

  assign icache_miss_ready_o = icache_miss_valid_i & ~grant_d
                             & mem_req_ready_i & ~full;
  assign dcache_miss_ready_o = grant_d & mem_req_ready_i & ~full;
  assign push = mem_req_valid_o & mem_req_ready_i;

  assign head_i = ~empty & (head == REQ_ICACHE);
  assign head_d = ~empty & (head == REQ_DCACHE);

  assign refill_icache_valid_o = mem_resp_valid_i & head_i;
  assign refill_dcache_valid_o = mem_resp_valid_i & head_d;
  assign refill_icache_data_o  = mem_resp_data_i;
  assign refill_dcache_data_o  = mem_resp_data_i;

  assign mem_resp_ready_o = (head_i & refill_icache_ready_i)
                          | (head_d & refill_dcache_ready_i);
  assign pop = mem_resp_valid_i & mem_resp_ready_o;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rr_last    <= REQ_DCACHE;
      resp_err_o <= 1'b0;
    end else begin
      if (push)
        rr_last <= grant_d;
      if (mem_resp_valid_i & empty)
        resp_err_o <= 1'b1;
    end
  end

  arb_id_fifo #(
    .DEPTH (MAX_OUTSTANDING),
    .CW    (CNT_WIDTH)
  ) u_id_fifo (
    .clk   (clk),
    .rst_n (rst_n),
    .push  (push),
    .din   (grant_d),
    .pop   (pop),
    .dout  (head),
    .full  (full),
    .empty (empty),
    .count (outstanding_o)
  );
endmodule

// File: tb/tb_mem_refill_arbiter.sv
// Scoreboard bench for mem_refill_arbiter: directed traffic,
// monitors check issued addresses and refill steering/data.
module tb_mem_refill_arbiter;
  import mem_arb_pkg::*;

  logic                  clk = 1'b0;
  logic                  rst_n;
  logic                  iv, dv;
  logic [ADDR_WIDTH-1:0] ia, da;
  logic                  i_rdy, d_rdy;
  logic                  ri_valid, rd_valid;
  logic                  ri_ready, rd_ready;
  logic [LINE_SIZE-1:0]  ri_data, rd_data;
  logic                  req_valid, req_ready;
  logic [ADDR_WIDTH-1:0] req_addr;
  logic                  resp_valid, resp_ready;
  logic [LINE_SIZE-1:0]  resp_data;
  logic [CNT_WIDTH-1:0]  outstanding;
  logic                  resp_err;

  mem_refill_arbiter dut (
    .clk                   (clk),
    .rst_n                 (rst_n),
    .icache_miss_valid_i   (iv),
    .icache_miss_ready_o   (i_rdy),
    .icache_miss_addr_i    (ia),
    .refill_icache_valid_o (ri_valid),
    .refill_icache_ready_i (ri_ready),
    .refill_icache_data_o  (ri_data),
    .dcache_miss_valid_i   (dv),
    .dcache_miss_ready_o   (d_rdy),
    .dcache_miss_addr_i    (da),
    .refill_dcache_valid_o (rd_valid),
    .refill_dcache_ready_i (rd_ready),
    .refill_dcache_data_o  (rd_data),
    .mem_req_valid_o       (req_valid),
    .mem_req_ready_i       (req_ready),
    .mem_req_addr_o        (req_addr),
    .mem_resp_valid_i      (resp_valid),
    .mem_resp_ready_o      (resp_ready),
    .mem_resp_data_i       (resp_data),
    .outstanding_o         (outstanding),
    .resp_err_o            (resp_err)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic        id;
    logic [63:0] addr;
  } req_t;

  req_t                 exp_req[$];
  logic                 exp_dest[$];
  logic [LINE_SIZE-1:0] exp_data[$];
  int total = 0;
  int bad   = 0;

  task automatic chk(input string nm, input logic [63:0] act,
                     input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h", nm, act, exp);
    end
  endtask

  function automatic logic [LINE_SIZE-1:0] mk(input int n);
    logic [31:0] w;
    w = 32'hC0DE0000 | n;
    return {16{w}};
  endfunction

  task automatic check_refill(input logic dest,
                              input logic [LINE_SIZE-1:0] d);
    logic                 ed;
    logic [LINE_SIZE-1:0] edata;
    if (exp_dest.size() == 0 || exp_data.size() == 0) begin
      chk("refill_unexpected", 64'd1, 64'd0);
    end else begin
      ed    = exp_dest.pop_front();
      edata = exp_data.pop_front();
      chk("refill_dest", {63'd0, dest}, {63'd0, ed});
      total++;
      if (d !== edata) begin
        bad++;
        $display("FAIL refill_data: got %0h want %0h",
                 d[63:0], edata[63:0]);
      end
    end
  endtask

  always @(negedge clk) begin
    if (rst_n) begin
      if (req_valid && req_ready) begin
        if (exp_req.size() == 0) begin
          chk("req_unexpected", 64'd1, 64'd0);
        end else begin
          req_t r;
          r = exp_req.pop_front();
          chk("req_id", {63'd0, d_rdy}, {63'd0, r.id});
          chk("req_addr", req_addr, r.addr);
        end
      end
      if (ri_valid && ri_ready) check_refill(REQ_ICACHE, ri_data);
      if (rd_valid && rd_ready) check_refill(REQ_DCACHE, rd_data);
    end
  end

  task automatic do_reset();
    rst_n = 1'b0;
    iv = 0; dv = 0; ia = '0; da = '0;
    req_ready = 1; ri_ready = 1; rd_ready = 1;
    resp_valid = 0; resp_data = '0;
    exp_req.delete(); exp_dest.delete(); exp_data.delete();
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
  endtask

  task automatic issue(input logic id, input logic [63:0] a);
    if (id) begin dv = 1; da = a; end
    else begin iv = 1; ia = a; end
    exp_req.push_back({id, line_align(a)});
    exp_dest.push_back(id);
    @(negedge clk);
    chk("issue_ready", {63'd0, id ? d_rdy : i_rdy}, 64'd1);
    @(posedge clk); #1;
    iv = 0; dv = 0;
  endtask

  task automatic respond(input logic [LINE_SIZE-1:0] d);
    resp_valid = 1; resp_data = d;
    exp_data.push_back(d);
    @(negedge clk);
    chk("resp_ready", {63'd0, resp_ready}, 64'd1);
    @(posedge clk); #1;
    resp_valid = 0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout want finish");
    $fatal(1);
  end

  initial begin
    do_reset();
    chk("rst_outstanding", 64'(outstanding), 64'd0);
    chk("rst_req_valid", {63'd0, req_valid}, 64'd0);
    chk("rst_i_rdy", {63'd0, i_rdy}, 64'd0);
    chk("rst_d_rdy", {63'd0, d_rdy}, 64'd0);
    chk("rst_refill_v", {62'd0, ri_valid, rd_valid}, 64'd0);
    chk("rst_resp_ready", {63'd0, resp_ready}, 64'd0);
    chk("rst_err", {63'd0, resp_err}, 64'd0);

    // single icache miss and refill
    issue(REQ_ICACHE, 64'h8000_1234);
    chk("t1_outstanding", 64'(outstanding), 64'd1);
    respond(mk(1));
    chk("t1_drained", 64'(outstanding), 64'd0);

    // both requesters held: round-robin from reset
    do_reset();
    iv = 1; ia = 64'h1000_0047;
    dv = 1; da = 64'h2000_00BF;
    exp_req.push_back({REQ_ICACHE, 64'h1000_0040});
    exp_req.push_back({REQ_DCACHE, 64'h2000_0080});
    exp_req.push_back({REQ_ICACHE, 64'h1000_0040});
    exp_req.push_back({REQ_DCACHE, 64'h2000_0080});
    exp_dest.push_back(REQ_ICACHE); exp_dest.push_back(REQ_DCACHE);
    exp_dest.push_back(REQ_ICACHE); exp_dest.push_back(REQ_DCACHE);
    repeat (4) @(posedge clk);
    #1 iv = 0; dv = 0;
    chk("t2_outstanding", 64'(outstanding), 64'd4);
    for (int k = 0; k < 4; k++) respond(mk(2 + k));
    chk("t2_drained", 64'(outstanding), 64'd0);

    // fill to capacity, pop does not unblock in the same cycle
    for (int k = 0; k < 4; k++)
      issue(REQ_ICACHE, 64'h3000_0000 + 64'(k * 64));
    chk("t3_full", 64'(outstanding), 64'd4);
    iv = 1; ia = 64'h3000_0100;
    @(negedge clk);
    chk("t3_req_valid", {63'd0, req_valid}, 64'd0);
    chk("t3_i_rdy_full", {63'd0, i_rdy}, 64'd0);
    @(posedge clk); #1;
    resp_valid = 1; resp_data = mk(10);
    exp_data.push_back(mk(10));
    @(negedge clk);
    chk("t3_i_rdy_pop", {63'd0, i_rdy}, 64'd0);
    chk("t3_resp_ready", {63'd0, resp_ready}, 64'd1);
    @(posedge clk); #1;
    resp_valid = 0;
    exp_req.push_back({REQ_ICACHE, 64'h3000_0100});
    exp_dest.push_back(REQ_ICACHE);
    @(negedge clk);
    chk("t3_i_rdy_back", {63'd0, i_rdy}, 64'd1);
    @(posedge clk); #1;
    iv = 0;
    chk("t3_refull", 64'(outstanding), 64'd4);
    for (int k = 0; k < 4; k++) respond(mk(11 + k));

    // dcache head stalled by its refill ready
    issue(REQ_DCACHE, 64'h4000_0010);
    rd_ready = 0;
    resp_valid = 1; resp_data = mk(20);
    exp_data.push_back(mk(20));
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      chk("t4_resp_ready", {63'd0, resp_ready}, 64'd0);
      chk("t4_rd_valid", {63'd0, rd_valid}, 64'd1);
      chk("t4_ri_valid", {63'd0, ri_valid}, 64'd0);
      @(posedge clk); #1;
    end
    rd_ready = 1;
    @(negedge clk);
    chk("t4_resp_go", {63'd0, resp_ready}, 64'd1);
    @(posedge clk); #1;
    resp_valid = 0;
    chk("t4_drained", 64'(outstanding), 64'd0);

    // simultaneous push/pop at count 2, across pointer wrap
    issue(REQ_ICACHE, 64'h5000_0000);
    issue(REQ_DCACHE, 64'h5000_0040);
    for (int k = 0; k < 4; k++) begin
      logic id;
      logic [63:0] a;
      id = k[0];
      a  = 64'h5000_1000 + 64'(k * 64) + 64'd5;
      if (id) begin dv = 1; da = a; end
      else begin iv = 1; ia = a; end
      exp_req.push_back({id, line_align(a)});
      exp_dest.push_back(id);
      resp_valid = 1; resp_data = mk(30 + k);
      exp_data.push_back(mk(30 + k));
      @(negedge clk);
      chk("t5_resp_ready", {63'd0, resp_ready}, 64'd1);
      chk("t5_req_ready", {63'd0, id ? d_rdy : i_rdy}, 64'd1);
      @(posedge clk); #1;
      iv = 0; dv = 0; resp_valid = 0;
      chk("t5_count", 64'(outstanding), 64'd2);
    end
    respond(mk(40));
    respond(mk(41));
    chk("t5_drained", 64'(outstanding), 64'd0);
    chk("q_req_empty", 64'(exp_req.size()), 64'd0);
    chk("q_dest_empty", 64'(exp_dest.size()), 64'd0);
    chk("q_data_empty", 64'(exp_data.size()), 64'd0);

    // response with nothing outstanding, then async reset
    do_reset();
    resp_valid = 1; resp_data = mk(99);
    @(negedge clk);
    chk("t6_resp_ready", {63'd0, resp_ready}, 64'd0);
    chk("t6_refill_v", {62'd0, ri_valid, rd_valid}, 64'd0);
    chk("t6_err_pre", {63'd0, resp_err}, 64'd0);
    @(posedge clk); #1;
    resp_valid = 0;
    chk("t6_err_set", {63'd0, resp_err}, 64'd1);
    repeat (3) @(posedge clk);
    #1 chk("t6_err_sticky", {63'd0, resp_err}, 64'd1);
    issue(REQ_ICACHE, 64'h6000_0000);
    issue(REQ_DCACHE, 64'h6000_0040);
    chk("t6_busy", 64'(outstanding), 64'd2);
    #2 rst_n = 1'b0;
    #1;
    chk("t6_async_cnt", 64'(outstanding), 64'd0);
    chk("t6_async_err", {63'd0, resp_err}, 64'd0);
    chk("t6_async_req", {63'd0, req_valid}, 64'd0);
    do_reset();
    chk("t6_post_cnt", 64'(outstanding), 64'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
